// File: rtl/rr_sched.sv
// rr_sched: round-robin scheduler granting locked, multi-cycle ownership of a shared resource.
// Define RR_SCHED_TIMEOUT_EN to force release of a grant held for TIMEOUT_CYC cycles.
module rr_sched #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [N-1:0]         i_req,
  input  logic                 i_done,
  output logic                 o_gnt_vld,
  output logic [$clog2(N)-1:0] o_gnt_enc,
  output logic [N-1:0]         o_gnt,
  output logic                 o_timeout
);

  localparam int W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   ptr_r, ptr_s;
  logic [W-1:0]   enc_r, enc_s;
  logic           vld_r, vld_s;
  logic [N-1:0]   gnt_r, gnt_s;
  logic           release_s;
  logic           found_s;
  logic [W-1:0]   pick_s;
  logic           timeout_s;

  // Scan last+1, last+2, ... wrapping mod N; 'last' itself is checked last (lowest priority).
  function automatic logic [W:0] rr_pick(input logic [N-1:0] req, input logic [W-1:0] last);
    logic [W:0]   res;
    logic [W-1:0] idx_w;
    int           idx;
    res = {1'b0, {W{1'b0}}};
    for (int i = N; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      idx_w = W'(idx);
      if (req[idx_w]) begin
        res = {1'b1, idx_w};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef RR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_r;

  assign timeout_s = (state_r == BUSY) && (cnt_r == CW'(TIMEOUT_CYC));

  // Hold-time counter: zero on every new grant, counts BUSY cycles otherwise.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_s == BUSY) && ((state_r == IDLE) || release_s)) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == BUSY) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state: arbitrate from ptr when idle, from the releasing owner on handoff.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    enc_s     = enc_r;
    vld_s     = vld_r;
    gnt_s     = gnt_r;
    release_s = (state_r == BUSY) && (i_done || timeout_s);
    {found_s, pick_s} = rr_pick(i_req, (state_r == BUSY) ? enc_r : ptr_r);
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = BUSY;
          enc_s   = pick_s;
          vld_s   = 1'b1;
          gnt_s   = {{(N-1){1'b0}}, 1'b1} << pick_s;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (release_s) begin
          ptr_s = enc_r;
          if (found_s) begin
            state_s = BUSY;
            enc_s   = pick_s;
            vld_s   = 1'b1;
            gnt_s   = {{(N-1){1'b0}}, 1'b1} << pick_s;
          end else begin
            state_s = IDLE;
            vld_s   = 1'b0;
            gnt_s   = {N{1'b0}};
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        ptr_s   = W'(N - 1);
        enc_s   = {W{1'b0}};
        vld_s   = 1'b0;
        gnt_s   = {N{1'b0}};
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE;
      ptr_r   <= W'(N - 1);
      enc_r   <= {W{1'b0}};
      vld_r   <= 1'b0;
      gnt_r   <= {N{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      enc_r   <= enc_s;
      vld_r   <= vld_s;
      gnt_r   <= gnt_s;
    end
  end

  assign o_gnt_vld = vld_r;
  assign o_gnt_enc = enc_r;
  assign o_gnt     = gnt_r;
  assign o_timeout = timeout_s;

endmodule
